// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : controle_multiciclo
// Purpose  : Multicycle control FSM for the RV64I-subset datapath. Sequences
//            fetch / decode / execute / memory / write-back and decodes every
//            datapath enable and mux select from the current state.
// Revision : 1.0 - initial release
// ============================================================================
module controle_multiciclo #(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        alu_out_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        iord,
  output logic [3:0]  imm_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_src,
  output logic [3:0]  state_o,
  output logic        instr_retired,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC_R     = 4'd3,
    S_EXEC_I     = 4'd4,
    S_ADDR       = 4'd5,
    S_MEM_RD     = 4'd6,
    S_MEM_WAIT   = 4'd7,
    S_WB_MEM     = 4'd8,
    S_WB_ALU     = 4'd9,
    S_MEM_WR     = 4'd10,
    S_BRANCH     = 4'd11,
    S_LUI        = 4'd12,
    S_JAL        = 4'd13,
    S_JALR       = 4'd14,
    S_ILLEGAL    = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] IMM_I  = 4'd0;
  localparam logic [3:0] IMM_S  = 4'd1;
  localparam logic [3:0] IMM_SB = 4'd2;
  localparam logic [3:0] IMM_U  = 4'd3;
  localparam logic [3:0] IMM_UJ = 4'd4;

  // Terminal count of the memory wait counter (shared by fetch and load).
  localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign state_o = state;
  // Register/immediate fields belong to the datapath, not to this controller.
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  // Only beq (000) and bne (001) reach BRANCH; other funct3 are trapped in DECODE.
  assign branch_taken = ((funct3 == 3'b000) &&  alu_zero) ||
                        ((funct3 == 3'b001) && !alu_zero);

  // State and wait counter; reset forces FETCH with no pending writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state selection and Moore-style output decode (pc_src in BRANCH follows alu_zero).
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    imm_sel       = IMM_I;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    wb_sel        = 2'd0;
    pc_src        = 2'd0;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        wait_cnt_next = 4'd0;
        state_next    = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        wait_cnt_next = wait_cnt + 4'd1;
        if (wait_cnt == LAST_WAIT) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative PC + imm into ALUOut serves as the branch/jal target.
        alu_src_b     = 2'd1;
        alu_out_write = 1'b1;
        if (opcode == OP_BRANCH)   imm_sel = IMM_SB;
        else if (opcode == OP_JAL) imm_sel = IMM_UJ;
        case (opcode)
          OP_R:      state_next = S_EXEC_R;
          OP_I:      state_next = S_EXEC_I;
          OP_LOAD,
          OP_STORE:  state_next = S_ADDR;
          OP_BRANCH: state_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          OP_LUI:    state_next = S_LUI;
          OP_JAL:    state_next = S_JAL;
          OP_JALR:   state_next = S_JALR;
          default:   state_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd2;
        alu_out_write = 1'b1;
        state_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd1;
        alu_op        = 2'd2;
        alu_out_write = 1'b1;
        state_next    = S_WB_ALU;
      end
      S_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd1;
        alu_out_write = 1'b1;
        imm_sel       = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next    = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord          = 1'b1;
        wait_cnt_next = 4'd0;
        state_next    = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        iord          = 1'b1;
        wait_cnt_next = wait_cnt + 4'd1;
        if (wait_cnt == LAST_WAIT) state_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write = 1'b1; wb_sel = 2'd1; pc_write = 1'b1; pc_src = 2'd2;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1; wb_sel = 2'd0; pc_write = 1'b1; pc_src = 2'd2;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      S_MEM_WR: begin
        iord = 1'b1; mem_write = 1'b1; pc_write = 1'b1; pc_src = 2'd2;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = 2'd1; pc_write = 1'b1;
        pc_src    = branch_taken ? 2'd1 : 2'd2;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      S_LUI: begin
        imm_sel = IMM_U; reg_write = 1'b1; wb_sel = 2'd2; pc_write = 1'b1; pc_src = 2'd2;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1; wb_sel = 2'd3; pc_write = 1'b1; pc_src = 2'd1;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 1'b1; alu_src_b = 2'd1;
        reg_write = 1'b1; wb_sel = 2'd3; pc_write = 1'b1; pc_src = 2'd3;
        instr_retired = 1'b1; state_next = S_FETCH;
      end
      default: begin
        // ILLEGAL: absorbing, nothing written until reset.
        illegal    = 1'b1;
        state_next = S_ILLEGAL;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_multiciclo
// Purpose  : Bench for controle_multiciclo with W=1 and W=3 instances; directed
//            instructions plus random ones against a per-instruction trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_multiciclo;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, aow, rw, mw, iord;
    logic [3:0] imm;
    logic       asa;
    logic [1:0] asb, aop, wb, pcs;
    logic       ret, ill;
  } ov_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [31:0] ins   [2];
  logic        az    [2];
  logic        pcw [2], irw [2], aow [2], rw [2], mw [2], iord [2], asa [2], ret [2], ill [2];
  logic [3:0]  imm [2], st [2];
  logic [1:0]  asb [2], aop [2], wb [2], pcs [2];
  ov_t         obs [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    controle_multiciclo #(.MEM_WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(rst_n[g]), .instr(ins[g]), .alu_zero(az[g]),
      .pc_write(pcw[g]), .ir_write(irw[g]), .alu_out_write(aow[g]),
      .reg_write(rw[g]), .mem_write(mw[g]), .iord(iord[g]), .imm_sel(imm[g]),
      .alu_src_a(asa[g]), .alu_src_b(asb[g]), .alu_op(aop[g]), .wb_sel(wb[g]),
      .pc_src(pcs[g]), .state_o(st[g]), .instr_retired(ret[g]), .illegal(ill[g])
    );
    assign obs[g] = {st[g], pcw[g], irw[g], aow[g], rw[g], mw[g], iord[g], imm[g],
                     asa[g], asb[g], aop[g], wb[g], pcs[g], ret[g], ill[g]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for one cycle of an instruction, from the phase it is in.
  function automatic ov_t exp_out(input int ph, input bit last, input logic [31:0] in, input logic z);
    ov_t o = '0;
    logic [6:0] op = in[6:0];
    logic [2:0] f3 = in[14:12];
    o.st = 4'(ph);
    case (ph)
      1: o.irw = last;
      2: begin
        o.asb = 2'd1; o.aow = 1'b1;
        o.imm = (op == 7'b1100011) ? 4'd2 : (op == 7'b1101111) ? 4'd4 : 4'd0;
      end
      3: begin o.asa = 1'b1; o.aop = 2'd2; o.aow = 1'b1; end
      4: begin o.asa = 1'b1; o.asb = 2'd1; o.aop = 2'd2; o.aow = 1'b1; end
      5: begin o.asa = 1'b1; o.asb = 2'd1; o.aow = 1'b1; o.imm = (op == 7'b0100011) ? 4'd1 : 4'd0; end
      6, 7: o.iord = 1'b1;
      8:  begin o.rw = 1'b1; o.wb = 2'd1; o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1; end
      9:  begin o.rw = 1'b1; o.wb = 2'd0; o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1; end
      10: begin o.iord = 1'b1; o.mw = 1'b1; o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1; end
      11: begin
        o.asa = 1'b1; o.aop = 2'd1; o.pcw = 1'b1; o.ret = 1'b1;
        o.pcs = (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z)) ? 2'd1 : 2'd2;
      end
      12: begin o.imm = 4'd3; o.rw = 1'b1; o.wb = 2'd2; o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1; end
      13: begin o.rw = 1'b1; o.wb = 2'd3; o.pcw = 1'b1; o.pcs = 2'd1; o.ret = 1'b1; end
      14: begin o.asa = 1'b1; o.asb = 2'd1; o.rw = 1'b1; o.wb = 2'd3; o.pcw = 1'b1; o.pcs = 2'd3; o.ret = 1'b1; end
      15: o.ill = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // Async reset: outputs must collapse to FETCH immediately, then release after an edge.
  task automatic do_reset(input int d, input string name);
    rst_n[d] = 1'b0;
    #1;
    check($sformatf("%s_rst_async d%0d", name, d), {7'b0, obs[d]}, 32'h0);
    @(posedge clk); #1;
    check($sformatf("%s_rst_held d%0d", name, d), {7'b0, obs[d]}, 32'h0);
    rst_n[d] = 1'b1;
  endtask

  // Runs one instruction from FETCH; entered and left at posedge+1 with the DUT in FETCH.
  // azmode < 0 randomizes alu_zero every cycle, otherwise holds it at that value.
  task automatic run(input int d, input logic [31:0] in, input int azmode, input string name);
    int w = (d == 0) ? 1 : 3;
    int q[$];
    bit trap = 1'b0;
    ins[d] = in;
    q.push_back(0);
    for (int i = 0; i < w; i++) q.push_back(i == w - 1 ? 17 : 1);
    q.push_back(2);
    case (in[6:0])
      7'b0110011: begin q.push_back(3); q.push_back(9); end
      7'b0010011: begin q.push_back(4); q.push_back(9); end
      7'b0000011: begin
        q.push_back(5); q.push_back(6);
        for (int i = 0; i < w; i++) q.push_back(7);
        q.push_back(8);
      end
      7'b0100011: begin q.push_back(5); q.push_back(10); end
      7'b1100011: if (in[14:12] <= 3'd1) q.push_back(11); else trap = 1'b1;
      7'b0110111: q.push_back(12);
      7'b1101111: q.push_back(13);
      7'b1100111: q.push_back(14);
      default:    trap = 1'b1;
    endcase
    if (trap) for (int i = 0; i < 25; i++) q.push_back(15);
    foreach (q[i]) begin
      az[d] = (azmode < 0) ? 1'($urandom) : 1'(azmode);
      @(negedge clk);
      check($sformatf("%s d%0d c%0d", name, d, i), {7'b0, obs[d]},
            {7'b0, exp_out(q[i] % 16, q[i] >= 16, in, az[d])});
      @(posedge clk); #1;
    end
    if (trap) do_reset(d, name);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: begin
        r[6:0] = 7'b1100011;
        if ($urandom_range(0, 3) != 0) r[14:12] = {2'b00, 1'($urandom)};
      end
      5: r[6:0] = 7'b0110111;
      6: r[6:0] = 7'b1101111;
      7: r[6:0] = 7'b1100111;
      default: ;
    endcase
    return r;
  endfunction

  logic [31:0] dir [10];
  initial begin
    dir = '{32'h002081B3, 32'h0000B103, 32'h0020B023, 32'h00208463, 32'h00209463,
            32'h123450B7, 32'h008000EF, 32'h000080E7, 32'h0000007F, 32'h0020A463};
    for (int d = 0; d < 2; d++) begin rst_n[d] = 1'b0; ins[d] = '0; az[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_w1", {7'b0, obs[0]}, 32'h0);
    check("reset_w3", {7'b0, obs[1]}, 32'h0);

    // W=1: release, step into FETCH_WAIT, then reset from there.
    rst_n[0] = 1'b1;
    ins[0]   = dir[0];
    @(negedge clk); check("first_fetch", {28'b0, st[0]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("fetch_wait", {28'b0, st[0]}, 32'd1);
    do_reset(0, "midfw");

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1;
      foreach (dir[i]) begin
        if (i == 3 || i == 4) begin
          run(d, dir[i], 1, $sformatf("dir%0d_z1", i));
          run(d, dir[i], 0, $sformatf("dir%0d_z0", i));
        end else begin
          run(d, dir[i], -1, $sformatf("dir%0d", i));
        end
      end
      for (int n = 0; n < 40; n++) run(d, rand_instr(), -1, $sformatf("rnd%0d", n));
      rst_n[d] = 1'b0;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
